omr_grade_sequencer: RTL and testbench



---
 rtl/omr_grade_sequencer_pkg.sv | 20 ++
 rtl/omr_grade_sequencer_if.sv | 44 ++++
 rtl/omr_grade_sequencer_answer_cmp.sv | 23 ++
 rtl/omr_grade_sequencer.sv | 136 +++++++++++++
 tb/tb_omr_grade_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/omr_grade_sequencer_pkg.sv
// Shared types and defaults for the OMR grading sequencer.
// Optional blank-answer detection is controlled by OMR_BLANK_DETECT_EN.
package omr_pkg;

   localparam int NUM_Q_DEF = 10;
   localparam int ANS_W_DEF = 4;

   typedef enum logic [1:0] {
      NOKEY   = 2'd0,
      READY   = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } omr_seq_state_t;

   typedef logic [ANS_W_DEF-1:0] answer_t;

   // An unmarked bubble row reads as all zeros.
   localparam answer_t BLANK_ANS = '0;

endpackage

// File: rtl/omr_grade_sequencer_if.sv
// Key, sheet and score signals of the grading sequencer.
// blank_count exists only when OMR_BLANK_DETECT_EN is defined.
interface omr_grade_sequencer_if #(
   parameter int NUM_Q = omr_pkg::NUM_Q_DEF,
   parameter int ANS_W = omr_pkg::ANS_W_DEF
);
   localparam int SCORE_W = $clog2(NUM_Q + 1);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready
   // are both high; the producer holds valid and data stable until then.
   logic                   key_load;
   logic [NUM_Q*ANS_W-1:0] key_data;
   logic                   key_valid;
   logic                   sheet_valid;
   logic                   sheet_ready;
   logic [NUM_Q*ANS_W-1:0] sheet_data;
   logic                   score_valid;
   logic                   score_ready;
   logic [SCORE_W-1:0]     score;
   logic [15:0]            sheet_count;
   logic                   busy;
`ifdef OMR_BLANK_DETECT_EN
   logic [SCORE_W-1:0]     blank_count;

   modport master (
      output key_load, key_data, sheet_valid, sheet_data, score_ready,
      input  key_valid, sheet_ready, score_valid, score, sheet_count, busy, blank_count
   );
   modport slave (
      input  key_load, key_data, sheet_valid, sheet_data, score_ready,
      output key_valid, sheet_ready, score_valid, score, sheet_count, busy, blank_count
   );
`else
   modport master (
      output key_load, key_data, sheet_valid, sheet_data, score_ready,
      input  key_valid, sheet_ready, score_valid, score, sheet_count, busy
   );
   modport slave (
      input  key_load, key_data, sheet_valid, sheet_data, score_ready,
      output key_valid, sheet_ready, score_valid, score, sheet_count, busy
   );
`endif

endinterface

// File: rtl/omr_grade_sequencer_answer_cmp.sv
// Single-answer comparator shared by every question of a sheet.
// With OMR_BLANK_DETECT_EN a blank answer is flagged and never matches.
module omr_answer_cmp
   import omr_pkg::*;
#(
   parameter int ANS_W = ANS_W_DEF
) (
   input  logic [ANS_W-1:0] key,
   input  logic [ANS_W-1:0] ans,
`ifdef OMR_BLANK_DETECT_EN
   output logic             blank,
`endif
   output logic             match
);

`ifdef OMR_BLANK_DETECT_EN
   assign blank = (ans == ANS_W'(BLANK_ANS));
   assign match = (ans == key) && !blank;
`else
   assign match = (ans == key);
`endif

endmodule

// File: rtl/omr_grade_sequencer.sv
// Grading sequencer: holds an answer key, scores one question per clock.
// OMR_BLANK_DETECT_EN adds blank detection and the blank_count output.
module omr_grade_sequencer
   import omr_pkg::*;
#(
   parameter int NUM_Q = NUM_Q_DEF,
   parameter int ANS_W = ANS_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   omr_grade_sequencer_if.slave  bus,
   output omr_seq_state_t        state
);

   localparam int SCORE_W = $clog2(NUM_Q + 1);
   localparam int IDX_W   = $clog2(NUM_Q);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_Q - 1);

   localparam logic [1:0] ST_NOKEY   = NOKEY;
   localparam logic [1:0] ST_READY   = READY;
   localparam logic [1:0] ST_COMPARE = COMPARE;
   localparam logic [1:0] ST_DONE    = DONE;

   logic [1:0]             cur_state;
   logic                   key_held;
   logic [NUM_Q*ANS_W-1:0] key_reg;
   logic [NUM_Q*ANS_W-1:0] sheet_reg;
   logic [IDX_W-1:0]       idx;
   logic [SCORE_W-1:0]     acc;
   logic [SCORE_W-1:0]     acc_next;
   logic [SCORE_W-1:0]     score_reg;
   logic [15:0]            count_reg;
   logic [ANS_W-1:0]       key_ans;
   logic [ANS_W-1:0]       sheet_ans;
   logic                   match;

   // One comparator, time-multiplexed across the questions by idx.
   assign key_ans   = key_reg[idx*ANS_W +: ANS_W];
   assign sheet_ans = sheet_reg[idx*ANS_W +: ANS_W];
   assign acc_next  = acc + SCORE_W'(match);

`ifdef OMR_BLANK_DETECT_EN
   logic               blank;
   logic [SCORE_W-1:0] blank_acc;
   logic [SCORE_W-1:0] blank_acc_next;
   logic [SCORE_W-1:0] blank_reg;

   assign blank_acc_next  = blank_acc + SCORE_W'(blank);
   assign bus.blank_count = blank_reg;

   omr_answer_cmp #(.ANS_W(ANS_W)) u_cmp (
      .key   (key_ans),
      .ans   (sheet_ans),
      .blank (blank),
      .match (match)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank_acc <= '0;
         blank_reg <= '0;
      end else if (cur_state == ST_READY && !bus.key_load && bus.sheet_valid) begin
         blank_acc <= '0;
      end else if (cur_state == ST_COMPARE) begin
         blank_acc <= blank_acc_next;
         if (idx == LAST_IDX) blank_reg <= blank_acc_next;
      end
   end
`else
   omr_answer_cmp #(.ANS_W(ANS_W)) u_cmp (
      .key   (key_ans),
      .ans   (sheet_ans),
      .match (match)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= ST_NOKEY;
         key_held  <= 1'b0;
         key_reg   <= '0;
         sheet_reg <= '0;
         idx       <= '0;
         acc       <= '0;
         score_reg <= '0;
         count_reg <= '0;
      end else begin
         case (cur_state)
            ST_NOKEY: begin
               if (bus.key_load) begin
                  key_reg   <= bus.key_data;
                  key_held  <= 1'b1;
                  cur_state <= ST_READY;
               end
            end
            ST_READY: begin
               // A key load wins over a sheet offered in the same cycle.
               if (bus.key_load) begin
                  key_reg <= bus.key_data;
               end else if (bus.sheet_valid) begin
                  sheet_reg <= bus.sheet_data;
                  acc       <= '0;
                  idx       <= '0;
                  cur_state <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               acc <= acc_next;
               if (idx == LAST_IDX) begin
                  idx       <= '0;
                  score_reg <= acc_next;
                  cur_state <= ST_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               if (bus.score_ready) begin
                  if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
                  cur_state <= ST_READY;
               end
            end
            default: cur_state <= ST_NOKEY;
         endcase
      end
   end

   assign bus.key_valid   = key_held;
   assign bus.sheet_ready = (cur_state == ST_READY) && !bus.key_load;
   assign bus.score_valid = (cur_state == ST_DONE);
   assign bus.busy        = (cur_state == ST_COMPARE) || (cur_state == ST_DONE);
   assign bus.score       = score_reg;
   assign bus.sheet_count = count_reg;
   assign state           = omr_seq_state_t'(cur_state);

endmodule

// File: tb/tb_omr_grade_sequencer.sv
// Scoreboard bench for omr_grade_sequencer; follows OMR_BLANK_DETECT_EN when defined.
module tb_omr_grade_sequencer;
   import omr_pkg::*;

   localparam int NUM_Q   = NUM_Q_DEF;
   localparam int ANS_W   = ANS_W_DEF;
   localparam int SCORE_W = $clog2(NUM_Q + 1);
   localparam int KW      = NUM_Q * ANS_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   omr_seq_state_t state;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   omr_grade_sequencer_if #(.NUM_Q(NUM_Q), .ANS_W(ANS_W)) bus ();

   omr_grade_sequencer #(.NUM_Q(NUM_Q), .ANS_W(ANS_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .state (state)
   );

   int checks = 0;
   int failures = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic int ref_score(input logic [KW-1:0] key, input logic [KW-1:0] sheet);
      int n = 0;
      for (int q = 0; q < NUM_Q; q++) begin
         logic [ANS_W-1:0] a;
         a = sheet[q*ANS_W +: ANS_W];
`ifdef OMR_BLANK_DETECT_EN
         if (a == '0) continue;
`endif
         if (a == key[q*ANS_W +: ANS_W]) n++;
      end
      return n;
   endfunction

   function automatic int ref_blank(input logic [KW-1:0] sheet);
      int n = 0;
      for (int q = 0; q < NUM_Q; q++)
         if (sheet[q*ANS_W +: ANS_W] == '0) n++;
      return n;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [SCORE_W-1:0] exp_q[$];
   logic [SCORE_W-1:0] exp_blank_q[$];
   int unsigned        accept_cyc_q[$];
   logic [KW-1:0]      model_key = '0;
   bit                 model_key_valid = 0;
   bit                 inflight = 0;
   int                 model_count = 0;
   bit                 prev_valid = 0;
   bit                 prev_stall = 0;
   logic [SCORE_W-1:0] prev_score = '0;

   initial forever begin
      @(negedge clk);
      if (reset) begin
         exp_q.delete();
         exp_blank_q.delete();
         accept_cyc_q.delete();
         model_key_valid = 0;
         inflight = 0;
         model_count = 0;
         prev_valid = 0;
         prev_stall = 0;
      end else begin
         check("busy", 32'(bus.busy), 32'(inflight));
         check("key_valid", 32'(bus.key_valid), 32'(model_key_valid));
         check("sheet_ready", 32'(bus.sheet_ready), 32'(model_key_valid && !inflight && !bus.key_load));
         check("sheet_count", 32'(bus.sheet_count), 32'(model_count));
         if (!inflight) check("score_valid_idle", 32'(bus.score_valid), 32'd0);
         if (prev_stall) begin
            check("score_valid_hold", 32'(bus.score_valid), 32'd1);
            check("score_stable", 32'(bus.score), 32'(prev_score));
         end
         if (bus.score_valid && !prev_valid) begin
            if (accept_cyc_q.size() == 0) check("latency_no_accept", 32'(bus.score_valid), 32'd0);
            else check("latency", cyc - accept_cyc_q.pop_front(), 32'(NUM_Q));
         end
         // Key loads only take effect while no sheet is being graded.
         if (bus.key_load && !inflight) begin
            model_key = bus.key_data;
            model_key_valid = 1;
         end
         if (bus.sheet_valid && bus.sheet_ready) begin
            exp_q.push_back(SCORE_W'(ref_score(model_key, bus.sheet_data)));
            exp_blank_q.push_back(SCORE_W'(ref_blank(bus.sheet_data)));
            accept_cyc_q.push_back(cyc + 1);
            inflight = 1;
         end
         if (bus.score_valid && bus.score_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_score", 32'(bus.score_valid), 32'd0);
            end else begin
               check("score", 32'(bus.score), 32'(exp_q.pop_front()));
`ifdef OMR_BLANK_DETECT_EN
               check("blank_count", 32'(bus.blank_count), 32'(exp_blank_q.pop_front()));
`else
               void'(exp_blank_q.pop_front());
`endif
            end
            inflight = 0;
            if (model_count < 65535) model_count++;
         end
         prev_valid = bus.score_valid;
         prev_stall = bus.score_valid && !bus.score_ready;
         prev_score = bus.score;
      end
   end

   // ---------------- score_ready driver ----------------
   int ready_mode = 1;  // 0 low, 1 high, 2 random
   initial begin
      bus.score_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.score_ready = 1'b0;
            1:       bus.score_ready = 1'b1;
            default: bus.score_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_key(input logic [KW-1:0] k);
      bus.key_load = 1'b1;
      bus.key_data = k;
      @(posedge clk);
      #1;
      bus.key_load = 1'b0;
   endtask

   task automatic send_sheet(input logic [KW-1:0] s);
      int n = 0;
      bus.sheet_valid = 1'b1;
      bus.sheet_data  = s;
      @(negedge clk);
      while (!bus.sheet_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("sheet_accept", 32'(bus.sheet_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.sheet_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (inflight && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(inflight), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_key_valid", 32'(bus.key_valid), 32'd0);
      check("rst_sheet_ready", 32'(bus.sheet_ready), 32'd0);
      check("rst_score_valid", 32'(bus.score_valid), 32'd0);
      check("rst_score", 32'(bus.score), 32'd0);
      check("rst_sheet_count", 32'(bus.sheet_count), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_state", 32'(state), 32'(NOKEY));
`ifdef OMR_BLANK_DETECT_EN
      check("rst_blank_count", 32'(bus.blank_count), 32'd0);
`endif
   endtask

   function automatic logic [KW-1:0] flip(input logic [KW-1:0] s, input int q);
      logic [ANS_W-1:0] a;
      logic [KW-1:0] r;
      r = s;
      a = s[q*ANS_W +: ANS_W];
      r[q*ANS_W +: ANS_W] = {a[ANS_W-2:0], a[ANS_W-1]};
      return r;
   endfunction

   function automatic logic [KW-1:0] rand_key();
      logic [KW-1:0] k;
      for (int q = 0; q < NUM_Q; q++) k[q*ANS_W +: ANS_W] = ANS_W'(1) << $urandom_range(0, ANS_W - 1);
      return k;
   endfunction

   function automatic logic [KW-1:0] rand_sheet(input logic [KW-1:0] k);
      logic [KW-1:0] s;
      for (int q = 0; q < NUM_Q; q++) begin
         int r = $urandom_range(0, 9);
         if (r < 6)       s[q*ANS_W +: ANS_W] = k[q*ANS_W +: ANS_W];
         else if (r == 6) s[q*ANS_W +: ANS_W] = '0;
         else             s[q*ANS_W +: ANS_W] = ANS_W'($urandom_range(0, (1 << ANS_W) - 1));
      end
      return s;
   endfunction

   // ---------------- stimulus ----------------
   logic [KW-1:0] key_a;
   logic [KW-1:0] key_b;
   logic [KW-1:0] key_r;
   logic [KW-1:0] sheet;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.key_load = 1'b0;
      bus.key_data = '0;
      bus.sheet_valid = 1'b0;
      bus.sheet_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      reset = 1'b0;

      // No key: a waiting sheet must never be accepted.
      bus.sheet_valid = 1'b1;
      bus.sheet_data  = rand_key();
      repeat (50) @(posedge clk);
      #1;
      bus.sheet_valid = 1'b0;
      check("nokey_state", 32'(state), 32'(NOKEY));

      // Reference key, identical sheet -> full marks.
      key_a = 40'h8421842184;
      ready_mode = 1;
      load_key(key_a);
      send_sheet(key_a);
      wait_idle();
      check("count_after_first", 32'(bus.sheet_count), 32'd1);

      // Questions 0, 5, 9 wrong, with 5 stalled cycles of back-pressure.
      ready_mode = 0;
      send_sheet(flip(flip(flip(key_a, 0), 5), 9));
      begin
         int n = 0;
         while (!bus.score_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("stall_score_valid", 32'(bus.score_valid), 32'd1);
         check("stall_score", 32'(bus.score), 32'd7);
      end
      repeat (5) @(posedge clk);
      ready_mode = 1;
      wait_idle();

      // Key load together with a sheet: the new key must grade it.
      key_b = key_a;
      for (int q = 0; q < NUM_Q; q++) key_b = flip(key_b, q);
      bus.key_load = 1'b1;
      bus.key_data = key_b;
      bus.sheet_valid = 1'b1;
      bus.sheet_data = key_b;
      @(posedge clk);
      #1;
      bus.key_load = 1'b0;
      send_sheet(key_b);
      repeat (2) @(posedge clk);
      #1;
      load_key(key_a);  // arrives mid-compare, must be ignored
      wait_idle();
      send_sheet(key_b);
      wait_idle();

      // Blank slot 3 in both key and sheet.
      key_r = key_a;
      key_r[3*ANS_W +: ANS_W] = '0;
      load_key(key_r);
      send_sheet(key_r);
      wait_idle();

      // Reset while comparing question 4.
      send_sheet(key_r);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Randomized traffic with random back-pressure and stray key loads.
      ready_mode = 2;
      key_r = rand_key();
      load_key(key_r);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            key_r = rand_key();
            load_key(key_r);
         end
         sheet = ($urandom_range(0, 7) == 0) ? key_r : rand_sheet(key_r);
         send_sheet(sheet);
      end
      ready_mode = 1;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
